// File: rtl/lc3_datapath.sv
// LC-3 core: PC/IR, 8x16 register file, ALU, NZP codes, hardwired control FSM
// and a unified word memory that runs a preloaded program out of reset.
module lc3_datapath #(
  parameter logic [15:0] PC_RESET = 16'h3000,
  parameter string       MEM_INIT = "",
  parameter int          ADDR_W   = 16
) (
  input  logic        i_CLK,
  input  logic        i_Reset,
  output logic [15:0] o_PC,
  output logic [15:0] o_IR,
  output logic [2:0]  o_NZP,
  output logic        o_Halted
);

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_HALT} state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  state_t      state, state_nxt;
  logic [15:0] pc, ir, mar;
  logic [2:0]  nzp;
  logic [15:0] regs [8];
  logic [15:0] mem  [2**ADDR_W];

  logic [3:0]  opcode;
  logic [2:0]  dr, sr1, sr2;
  logic [15:0] sr1_val, sr2_val, alu_b, alu_out;
  logic [15:0] pc_off9, pc_off11, base_off6;
  logic [15:0] mem_addr, mem_rdata;
  logic        is_load, is_store, is_halt;

  logic        ld_ir, ld_pc, ld_mar, reg_we, set_cc, mem_we;
  logic [15:0] pc_nxt, mar_nxt, reg_wdata;
  logic [2:0]  reg_waddr;

  function automatic logic signed [15:0] sext5(input logic [4:0] f);
    return {{11{f[4]}}, f};
  endfunction

  function automatic logic signed [15:0] sext6(input logic [5:0] f);
    return {{10{f[5]}}, f};
  endfunction

  function automatic logic signed [15:0] sext9(input logic [8:0] f);
    return {{7{f[8]}}, f};
  endfunction

  function automatic logic signed [15:0] sext11(input logic [10:0] f);
    return {{5{f[10]}}, f};
  endfunction

  function automatic logic [2:0] cond_code(input logic [15:0] r);
    if (r[15])          return 3'b100;
    else if (r == '0)   return 3'b010;
    else                return 3'b001;
  endfunction

  assign opcode    = ir[15:12];
  assign dr        = ir[11:9];
  assign sr1       = ir[8:6];
  assign sr2       = ir[2:0];
  assign sr1_val   = regs[sr1];
  assign sr2_val   = regs[sr2];
  // pc already holds the incremented PC once FETCH has completed
  assign pc_off9   = pc + sext9(ir[8:0]);
  assign pc_off11  = pc + sext11(ir[10:0]);
  assign base_off6 = sr1_val + sext6(ir[5:0]);
  assign is_load   = (opcode == OP_LD) || (opcode == OP_LDR);
  assign is_store  = (opcode == OP_ST) || (opcode == OP_STR);
  assign is_halt   = (opcode == OP_TRAP) && (ir[7:0] == 8'h25);

  assign mem_addr  = (state == ST_MEM) ? mar : pc;
  assign mem_rdata = mem[mem_addr[ADDR_W-1:0]];

  always_comb begin
    alu_b = ir[5] ? sext5(ir[4:0]) : sr2_val;
    case (opcode)
      OP_ADD:  alu_out = sr1_val + alu_b;
      OP_AND:  alu_out = sr1_val & alu_b;
      default: alu_out = ~sr1_val;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_Reset) begin
    if (!i_Reset) state <= ST_FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (is_load || is_store) state_nxt = ST_MEM;
        else if (is_halt)        state_nxt = ST_HALT;
        else                     state_nxt = ST_FETCH;
      end
      ST_MEM:   state_nxt = ST_FETCH;
      default:  state_nxt = ST_HALT;
    endcase
  end

  always_comb begin
    ld_ir     = 1'b0;
    ld_pc     = 1'b0;
    pc_nxt    = pc;
    ld_mar    = 1'b0;
    mar_nxt   = pc_off9;
    reg_we    = 1'b0;
    reg_waddr = dr;
    reg_wdata = alu_out;
    set_cc    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      ST_FETCH: begin
        ld_ir  = 1'b1;
        ld_pc  = 1'b1;
        pc_nxt = pc + 16'd1;
      end
      ST_EXEC: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: begin
            reg_we = 1'b1;
            set_cc = 1'b1;
          end
          OP_BR: begin
            ld_pc  = |(dr & nzp);
            pc_nxt = pc_off9;
          end
          OP_JMP: begin
            ld_pc  = 1'b1;
            pc_nxt = sr1_val;
          end
          // link value is the pre-jump PC; a JSRR through R7 reads the old R7
          OP_JSR: begin
            ld_pc     = 1'b1;
            pc_nxt    = ir[11] ? pc_off11 : sr1_val;
            reg_we    = 1'b1;
            reg_waddr = 3'd7;
            reg_wdata = pc;
          end
          OP_LEA: begin
            reg_we    = 1'b1;
            reg_wdata = pc_off9;
            set_cc    = 1'b1;
          end
          OP_LD, OP_ST: begin
            ld_mar  = 1'b1;
            mar_nxt = pc_off9;
          end
          OP_LDR, OP_STR: begin
            ld_mar  = 1'b1;
            mar_nxt = base_off6;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        reg_we    = is_load;
        reg_wdata = mem_rdata;
        set_cc    = is_load;
        mem_we    = is_store;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_Reset) begin
    if (!i_Reset) begin
      pc  <= PC_RESET;
      ir  <= '0;
      mar <= '0;
      nzp <= 3'b010;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (ld_ir)  ir <= mem_rdata;
      if (ld_pc)  pc <= pc_nxt;
      if (ld_mar) mar <= mar_nxt;
      if (reg_we) regs[reg_waddr] <= reg_wdata;
      if (set_cc) nzp <= cond_code(reg_wdata);
    end
  end

  // memory is never cleared; mem_we follows the asynchronously reset FSM
  always_ff @(posedge i_CLK) begin
    if (mem_we) mem[mar[ADDR_W-1:0]] <= regs[dr];
  end

  assign o_PC     = pc;
  assign o_IR     = ir;
  assign o_NZP    = nzp;
  assign o_Halted = (state == ST_HALT);

endmodule

// File: tb/tb_lc3_datapath.sv
// Bench for lc3_datapath: an instruction-level LC-3 interpreter predicts the
// per-cycle PC/IR/NZP/halted trace, which a monitor compares against the core.
module tb_lc3_datapath;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc, ir;
  logic [2:0]  nzp;
  logic        halted;

  lc3_datapath #(.PC_RESET(16'h3000)) dut (
    .i_CLK   (clk),
    .i_Reset (rst_n),
    .o_PC    (pc),
    .o_IR    (ir),
    .o_NZP   (nzp),
    .o_Halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ir;
    logic [2:0]  nzp;
    logic        halted;
  } obs_t;

  obs_t        exp_q[$];
  obs_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [15:0] m_mem [65536];
  logic [15:0] m_reg [8];
  logic [15:0] m_pc;
  logic [2:0]  m_nzp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // monitor: one expected observation per clock, sampled on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("trace", {28'b0, pc, ir, nzp, halted}, {28'b0, mon_e});
    end
  end

  function automatic logic [15:0] sx(input logic [15:0] f, input int bits);
    int v;
    v = int'(f) & ((1 << bits) - 1);
    if (v >= (1 << (bits - 1))) v -= (1 << bits);
    return 16'(v);
  endfunction

  function automatic logic [2:0] cc(input logic [15:0] r);
    if (r[15])     return 3'b100;
    if (r == 16'h0) return 3'b010;
    return 3'b001;
  endfunction

  function automatic obs_t mk(input logic [15:0] p, input logic [15:0] i,
                              input logic [2:0] n, input logic h);
    obs_t o;
    o.pc = p; o.ir = i; o.nzp = n; o.halted = h;
    return o;
  endfunction

  task automatic model_reset();
    m_pc  = 16'h3000;
    m_nzp = 3'b010;
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
  endtask

  // ISA interpreter: FETCH+EXEC is two cycles, memory ops add a third
  task automatic model_run(input int max_instr, input int halt_cycles);
    logic [15:0] inst, npc, a, r, tgt;
    logic [2:0]  d, s1;
    logic [3:0]  op;
    for (int k = 0; k < max_instr; k++) begin
      inst = m_mem[m_pc];
      npc  = m_pc + 16'd1;
      op   = inst[15:12];
      d    = inst[11:9];
      s1   = inst[8:6];
      exp_q.push_back(mk(npc, inst, m_nzp, 1'b0));
      m_pc = npc;
      case (op)
        4'h1, 4'h5, 4'h9: begin
          a = inst[5] ? sx(inst, 5) : m_reg[inst[2:0]];
          if (op == 4'h1)      r = m_reg[s1] + a;
          else if (op == 4'h5) r = m_reg[s1] & a;
          else                 r = ~m_reg[s1];
          m_reg[d] = r;
          m_nzp    = cc(r);
        end
        4'h0: if ((d & m_nzp) != 3'b000) m_pc = npc + sx(inst, 9);
        4'hC: m_pc = m_reg[s1];
        4'h4: begin
          tgt      = inst[11] ? npc + sx(inst, 11) : m_reg[s1];
          m_reg[7] = npc;
          m_pc     = tgt;
        end
        4'hE: begin
          r        = npc + sx(inst, 9);
          m_reg[d] = r;
          m_nzp    = cc(r);
        end
        4'h2, 4'h3, 4'h6, 4'h7: begin
          a = (op == 4'h2 || op == 4'h3) ? npc + sx(inst, 9) : m_reg[s1] + sx(inst, 6);
          exp_q.push_back(mk(npc, inst, m_nzp, 1'b0));
          if (op == 4'h2 || op == 4'h6) begin
            m_reg[d] = m_mem[a];
            m_nzp    = cc(m_mem[a]);
          end else begin
            m_mem[a] = m_reg[d];
          end
        end
        default: ;
      endcase
      if (op == 4'hF && inst[7:0] == 8'h25) begin
        for (int c = 0; c <= halt_cycles; c++) exp_q.push_back(mk(npc, inst, m_nzp, 1'b1));
        break;
      end
      exp_q.push_back(mk(m_pc, inst, m_nzp, 1'b0));
    end
  endtask

  task automatic poke(input logic [15:0] addr, input logic [15:0] val);
    dut.mem[addr] = val;
    m_mem[addr]   = val;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 65536; a++) begin
      dut.mem[16'(a)] = 16'h0;
      m_mem[16'(a)]   = 16'h0;
    end
  endtask

  // called just after a falling edge; leaves reset asserted across one rising edge
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_pc", pc, 16'h3000);
    check("rst_ir", ir, 16'h0);
    check("rst_nzp", nzp, 3'b010);
    check("rst_halted", halted, 1'b0);
    @(negedge clk); #1;
    for (int i = 0; i < 8; i++) check($sformatf("rst_r%0d", i), dut.regs[i], 16'h0);
    model_reset();
  endtask

  task automatic run_trace(input int bound);
    rst_n = 1'b1;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    check("trace_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_state();
    int diffs;
    diffs = 0;
    for (int i = 0; i < 8; i++) check($sformatf("reg%0d", i), dut.regs[i], m_reg[i]);
    for (int a = 0; a < 65536; a++)
      if (dut.mem[16'(a)] !== m_mem[16'(a)]) diffs++;
    check("mem_image", diffs, 0);
  endtask

  function automatic logic [15:0] rand_inst();
    logic [2:0] d, s, t;
    d = 3'($urandom);
    s = 3'($urandom);
    t = 3'($urandom);
    case ($urandom_range(0, 14))
      0:  return {4'h1, d, s, 3'b000, t};
      1:  return {4'h1, d, s, 1'b1, 5'($urandom)};
      2:  return {4'h5, d, s, 1'b1, 5'($urandom)};
      3:  return {4'h5, d, s, 3'b000, t};
      4:  return {4'h9, d, s, 6'h3F};
      5:  return {4'hE, d, 9'($urandom_range(0, 40)) - 9'd20};
      6:  return {4'h0, 3'($urandom), 9'($urandom_range(0, 9)) - 9'd3};
      7:  return {4'h2, d, 9'($urandom)};
      8:  return {4'h3, d, 9'($urandom)};
      9:  return {4'h6, d, s, 6'($urandom)};
      10: return {4'h7, d, s, 6'($urandom)};
      11: return {4'h4, 1'b1, 11'($urandom_range(0, 12)) - 11'd4};
      12: return {4'hF, 4'h0, 8'($urandom_range(8'h20, 8'h24))};
      13: return {4'h8, 12'($urandom)};
      default: return {4'hC, 3'b000, s, 6'b000000};
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    clear_mem();
    @(negedge clk); #1;

    // reset state, then AND/ADD immediate
    do_reset();
    poke(16'h3000, 16'h5020);
    poke(16'h3001, 16'h103D);
    model_run(2, 0);
    run_trace(50);
    check("add_r0", dut.regs[0], 16'hFFFD);
    check("add_nzp", nzp, 3'b100);
    check("add_pc", pc, 16'h3002);
    check_state();

    // LD then STR through a loaded base register
    do_reset();
    clear_mem();
    poke(16'h3000, 16'h24FE);
    poke(16'h3001, 16'h22FF);
    poke(16'h3002, 16'h7281);
    poke(16'h3003, 16'hF025);
    poke(16'h30FF, 16'h3200);
    poke(16'h3101, 16'h1234);
    model_run(10, 4);
    run_trace(60);
    check("ld_r1", dut.regs[1], 16'h1234);
    check("ld_nzp", nzp, 3'b001);
    check("str_mem", dut.mem[16'h3201], 16'h1234);
    check("halt1", halted, 1'b1);
    check_state();

    // branches, JSR, HALT held for 1000 cycles
    do_reset();
    clear_mem();
    poke(16'h3000, 16'h5020);
    poke(16'h3001, 16'h0403);
    poke(16'h3005, 16'h0807);
    poke(16'h3006, 16'h0E09);
    poke(16'h3010, 16'h4805);
    poke(16'h3016, 16'hF025);
    model_run(20, 1000);
    run_trace(1100);
    check("jsr_r7", dut.regs[7], 16'h3011);
    check("halt_pc", pc, 16'h3017);
    check("halt2", halted, 1'b1);
    check_state();

    // reset clears HALT and the same program runs again from x3000
    do_reset();
    model_run(20, 2);
    run_trace(100);
    check("rerun_r7", dut.regs[7], 16'h3011);
    check("rerun_pc", pc, 16'h3017);

    // reset during EXEC of an ST abandons the store
    do_reset();
    clear_mem();
    poke(16'h3000, 16'h3010);
    poke(16'h3011, 16'hBEEF);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("st_fetch_ir", ir, 16'h3010);
    rst_n = 1'b0;
    #1;
    check("st_abort_pc", pc, 16'h3000);
    @(negedge clk); @(negedge clk); #1;
    check("st_abort_mem", dut.mem[16'h3011], 16'hBEEF);

    // randomized programs against the interpreter
    for (int run = 0; run < 6; run++) begin
      do_reset();
      clear_mem();
      for (int a = 0; a < 64; a++) poke(16'h3000 + 16'(a), rand_inst());
      poke(16'h3040, 16'hF025);
      for (int a = 16'h3041; a < 16'h3140; a++) poke(16'(a), 16'($urandom));
      for (int a = 16'h2F00; a < 16'h3000; a++) poke(16'(a), 16'($urandom));
      model_run(120, 3);
      run_trace(600);
      check("rand_pc", pc, m_pc);
      check("rand_nzp", nzp, m_nzp);
      check_state();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
